// File: rtl/onehot_pulse_decoder_pkg.sv
// Shared types and width helpers for the one-hot pulse decoder and the matching encoder bench.
package onehot_pulse_decoder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  localparam int unsigned CODE_W_DEF   = 4;
  localparam int unsigned ONEHOT_W_DEF = 2 ** CODE_W_DEF;

  function automatic int unsigned onehot_width(input int unsigned code_w);
    return 2 ** code_w;
  endfunction

  // Counter must hold both HOLD-1 and GAP-1, and is never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned hold, input int unsigned gap);
    int unsigned m;
    m = 2;
    if (hold > m) m = hold;
    if (gap > m) m = gap;
    return $clog2(m);
  endfunction

endpackage

// File: rtl/onehot_dec_comb.sv
// Pure combinational CODE_W-to-2**CODE_W one-hot decoder.
module onehot_dec_comb
  import onehot_pulse_decoder_pkg::*;
#(
  parameter int unsigned CODE_W = CODE_W_DEF,
  parameter int unsigned OUT_W  = onehot_width(CODE_W)
) (
  input  logic [CODE_W-1:0] code_i,
  output logic [OUT_W-1:0]  onehot_o
);

  always_comb begin
    // NOTE: assign a default before any conditional/indexed write so no latch is inferred.
    onehot_o         = '0;
    onehot_o[code_i] = 1'b1;
  end

endmodule

// File: rtl/onehot_pulse_decoder.sv
// Handshaked index-to-one-hot decoder: registers the decoded line, holds it HOLD cycles, then blanks GAP cycles.
module onehot_pulse_decoder
  import onehot_pulse_decoder_pkg::*;
#(
  parameter  int unsigned CODE_W = CODE_W_DEF,
  parameter  int unsigned HOLD   = 4,
  parameter  int unsigned GAP    = 1,
  localparam int unsigned OUT_W  = onehot_width(CODE_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CODE_W-1:0] in_code,
  output logic [OUT_W-1:0]  out_onehot,
  output logic              out_valid,
  output logic              busy
);

  localparam int unsigned CNT_W = cnt_width(HOLD, GAP);
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'((GAP == 0) ? 0 : GAP - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [OUT_W-1:0] onehot_q, onehot_d;
  logic             valid_q, valid_d;
  logic [OUT_W-1:0] dec_onehot;

  onehot_dec_comb #(
    .CODE_W (CODE_W),
    .OUT_W  (OUT_W)
  ) u_dec (
    .code_i   (in_code),
    .onehot_o (dec_onehot)
  );

  assign in_ready   = (state_q == ST_IDLE) && !flush;
  assign busy       = (state_q != ST_IDLE);
  assign out_onehot = onehot_q;
  assign out_valid  = valid_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    onehot_d = onehot_q;
    valid_d  = valid_q;

    if (flush) begin
      state_d  = ST_IDLE;
      cnt_d    = '0;
      onehot_d = '0;
      valid_d  = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            onehot_d = dec_onehot;
            valid_d  = 1'b1;
            cnt_d    = HOLD_LOAD;
            state_d  = ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (cnt_q == '0) begin
            onehot_d = '0;
            valid_d  = 1'b0;
            // With no gap the block returns to IDLE, leaving exactly one blank cycle before the next accept.
            if (GAP > 0) begin
              state_d = ST_GAP;
              cnt_d   = GAP_LOAD;
            end else begin
              state_d = ST_IDLE;
              cnt_d   = '0;
            end
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        ST_GAP: begin
          if (cnt_q == '0) begin
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        default: begin
          state_d  = ST_IDLE;
          cnt_d    = '0;
          onehot_d = '0;
          valid_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      onehot_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      onehot_q <= onehot_d;
      valid_q  <= valid_d;
    end
  end

  a_onehot0 : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(out_onehot));
  a_valid_matches : assert property (@(posedge clk) disable iff (!rst_n) out_valid == (|out_onehot));

endmodule

// File: tb/tb_onehot_pulse_decoder.sv
// Self-checking bench: table vectors, hand sequences and a timing-arithmetic reference model on two configurations.
module tb_onehot_pulse_decoder;
  import onehot_pulse_decoder_pkg::*;

  localparam int OW = ONEHOT_W_DEF;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid [2];
  logic          flush_s  [2];
  logic [3:0]    in_code  [2];
  logic          ready    [2];
  logic [OW-1:0] onehot   [2];
  logic          ovalid   [2];
  logic          busy     [2];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: last accept edge index and its code; output timing follows from edge distance.
  int         hold_p [2] = '{4, 4};
  int         gap_p  [2] = '{1, 0};
  int         acc_t  [2];
  logic [3:0] acc_code [2];
  int         edge_n = 0;

  always #5 clk = ~clk;

  onehot_pulse_decoder #(.CODE_W(4), .HOLD(4), .GAP(1)) dut_g1 (
    .clk(clk), .rst_n(rst_n), .flush(flush_s[0]), .in_valid(in_valid[0]), .in_ready(ready[0]),
    .in_code(in_code[0]), .out_onehot(onehot[0]), .out_valid(ovalid[0]), .busy(busy[0])
  );

  onehot_pulse_decoder #(.CODE_W(4), .HOLD(4), .GAP(0)) dut_g0 (
    .clk(clk), .rst_n(rst_n), .flush(flush_s[1]), .in_valid(in_valid[1]), .in_ready(ready[1]),
    .in_code(in_code[1]), .out_onehot(onehot[1]), .out_valid(ovalid[1]), .busy(busy[1])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] encode(input logic [OW-1:0] oh);
    logic [3:0] r;
    r = '0;
    for (int i = 0; i < OW; i++) if (oh[i]) r = 4'(i);
    return r;
  endfunction

  function automatic bit m_busy(input int k, input int e);
    return (e - acc_t[k]) < (hold_p[k] + gap_p[k]);
  endfunction

  task automatic model_reset();
    for (int j = 0; j < 2; j++) begin
      acc_t[j]    = -100000;
      acc_code[j] = '0;
    end
  endtask

  task automatic idle_inputs();
    for (int j = 0; j < 2; j++) begin
      in_valid[j] = 1'b0;
      flush_s[j]  = 1'b0;
      in_code[j]  = 4'($urandom);
    end
  endtask

  task automatic model_compare();
    int d;
    logic [OW-1:0] exp_oh;
    bit exp_v, exp_b;
    for (int j = 0; j < 2; j++) begin
      d      = (edge_n - 1) - acc_t[j];
      exp_v  = d < hold_p[j];
      exp_b  = d < (hold_p[j] + gap_p[j]);
      exp_oh = exp_v ? OW'(1 << acc_code[j]) : '0;
      check($sformatf("model_onehot[%0d]", j), 32'(onehot[j]), 32'(exp_oh));
      check($sformatf("model_valid[%0d]", j), 32'(ovalid[j]), 32'(exp_v));
      check($sformatf("model_busy[%0d]", j), 32'(busy[j]), 32'(exp_b));
      check($sformatf("model_ready[%0d]", j), 32'(ready[j]), 32'(!exp_b));
      if (ovalid[j]) check($sformatf("encode_roundtrip[%0d]", j), 32'(encode(onehot[j])), 32'(acc_code[j]));
    end
  endtask

  // One clock: drive instance k at the negedge, update the model on the edge, compare after it.
  task automatic cycle(input int k, input logic v, input logic [3:0] c, input logic f);
    bit rdy [2];
    @(negedge clk);
    idle_inputs();
    in_valid[k] = v;
    in_code[k]  = c;
    flush_s[k]  = f;
    #1;
    for (int j = 0; j < 2; j++) begin
      rdy[j] = !m_busy(j, edge_n - 1) && !flush_s[j];
      check($sformatf("ready_pre[%0d]", j), 32'(ready[j]), 32'(rdy[j]));
    end
    @(posedge clk);
    for (int j = 0; j < 2; j++) begin
      if (flush_s[j]) acc_t[j] = -100000;
      else if (in_valid[j] && rdy[j]) begin
        acc_t[j]    = edge_n;
        acc_code[j] = in_code[j];
      end
    end
    edge_n++;
    #1;
    idle_inputs();
    #1;
    model_compare();
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    #1;
    for (int j = 0; j < 2; j++) begin
      check($sformatf("reset_onehot[%0d]", j), 32'(onehot[j]), 32'h0);
      check($sformatf("reset_valid[%0d]", j), 32'(ovalid[j]), 32'h0);
      check($sformatf("reset_busy[%0d]", j), 32'(busy[j]), 32'h0);
      check($sformatf("reset_ready[%0d]", j), 32'(ready[j]), 32'h1);
    end
  endtask

  typedef struct {
    logic          v;
    logic [3:0]    c;
    logic [OW-1:0] exp_oh;
    logic          exp_rdy;
  } vec_t;

  vec_t tbl [19];
  int   seq [18];
  logic [OW-1:0] g0_exp [10];

  initial begin
    // Single accept of 5, then boundary codes 0 and 15 with in_code changes during HOLD/GAP.
    tbl[0]  = '{1'b1, 4'd5,  16'h0020, 1'b0};
    tbl[1]  = '{1'b0, 4'd0,  16'h0020, 1'b0};
    tbl[2]  = '{1'b0, 4'd9,  16'h0020, 1'b0};
    tbl[3]  = '{1'b0, 4'd0,  16'h0020, 1'b0};
    tbl[4]  = '{1'b0, 4'd0,  16'h0000, 1'b0};
    tbl[5]  = '{1'b0, 4'd0,  16'h0000, 1'b1};
    tbl[6]  = '{1'b0, 4'd0,  16'h0000, 1'b1};
    tbl[7]  = '{1'b1, 4'd0,  16'h0001, 1'b0};
    tbl[8]  = '{1'b1, 4'd15, 16'h0001, 1'b0};
    tbl[9]  = '{1'b1, 4'd15, 16'h0001, 1'b0};
    tbl[10] = '{1'b1, 4'd15, 16'h0001, 1'b0};
    tbl[11] = '{1'b1, 4'd15, 16'h0000, 1'b0};
    tbl[12] = '{1'b1, 4'd15, 16'h0000, 1'b1};
    tbl[13] = '{1'b1, 4'd15, 16'h8000, 1'b0};
    tbl[14] = '{1'b0, 4'd0,  16'h8000, 1'b0};
    tbl[15] = '{1'b0, 4'd0,  16'h8000, 1'b0};
    tbl[16] = '{1'b0, 4'd0,  16'h8000, 1'b0};
    tbl[17] = '{1'b0, 4'd0,  16'h0000, 1'b0};
    tbl[18] = '{1'b0, 4'd0,  16'h0000, 1'b1};

    seq = '{3, 7, 9, 11, 4, 2, 12, 14, 1, 0, 6, 13, 10, 5, 8, 15, 3, 7};
    g0_exp = '{16'h0002, 16'h0002, 16'h0002, 16'h0002, 16'h0000,
               16'h0004, 16'h0004, 16'h0004, 16'h0004, 16'h0000};

    model_reset();
    do_reset();

    for (int i = 0; i < 19; i++) begin
      cycle(0, tbl[i].v, tbl[i].c, 1'b0);
      check($sformatf("tbl_onehot[%0d]", i), 32'(onehot[0]), 32'(tbl[i].exp_oh));
      check($sformatf("tbl_valid[%0d]", i), 32'(ovalid[0]), 32'(|tbl[i].exp_oh));
      check($sformatf("tbl_ready[%0d]", i), 32'(ready[0]), 32'(tbl[i].exp_rdy));
    end

    // Continuous in_valid, code changing every cycle: accepts land every HOLD+GAP+1 = 6 edges.
    for (int i = 0; i < 18; i++) begin
      cycle(0, 1'b1, 4'(seq[i]), 1'b0);
      check($sformatf("cont_onehot[%0d]", i), 32'(onehot[0]),
            ((i % 6) < 4) ? (32'h1 << seq[6 * (i / 6)]) : 32'h0);
    end
    repeat (2) cycle(0, 1'b0, 4'd0, 1'b0);

    // Flush during the second HOLD cycle collides with a new code 6.
    cycle(0, 1'b1, 4'd2, 1'b0);
    check("flush_pre_hold", 32'(onehot[0]), 32'h0004);
    cycle(0, 1'b0, 4'd0, 1'b0);
    @(negedge clk);
    idle_inputs();
    flush_s[0]  = 1'b1;
    in_valid[0] = 1'b1;
    in_code[0]  = 4'd6;
    #1;
    check("flush_ready_low", 32'(ready[0]), 32'h0);
    @(posedge clk);
    acc_t[0] = -100000;
    edge_n++;
    #1;
    idle_inputs();
    #1;
    check("flush_onehot_zero", 32'(onehot[0]), 32'h0);
    check("flush_ready_after", 32'(ready[0]), 32'h1);
    model_compare();
    cycle(0, 1'b0, 4'd0, 1'b0);
    check("flush_code6_dropped", 32'(onehot[0]), 32'h0);

    // Async reset mid-HOLD: outputs must drop before the next edge.
    cycle(0, 1'b1, 4'd8, 1'b0);
    #1;
    check("arst_pre_onehot", 32'(onehot[0]), 32'h0100);
    rst_n = 1'b0;
    #1;
    check("arst_onehot", 32'(onehot[0]), 32'h0);
    check("arst_valid", 32'(ovalid[0]), 32'h0);
    check("arst_busy", 32'(busy[0]), 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    #1;
    check("arst_release_busy", 32'(busy[0]), 32'h0);
    check("arst_release_ready", 32'(ready[0]), 32'h1);

    // GAP=0 instance: back-to-back 1 then 2 with in_valid held high.
    for (int i = 0; i < 10; i++) begin
      cycle(1, 1'b1, (i == 0) ? 4'd1 : 4'd2, 1'b0);
      check($sformatf("gap0_onehot[%0d]", i), 32'(onehot[1]), 32'(g0_exp[i]));
    end
    repeat (2) cycle(1, 1'b0, 4'd0, 1'b0);

    // Randomized traffic on both configurations against the model.
    for (int i = 0; i < 400; i++) begin
      cycle(int'($urandom_range(0, 1)), ($urandom_range(0, 9) < 7), 4'($urandom),
            ($urandom_range(0, 19) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
